apb_mem_arbiter: RTL and testbench
==================================

Name: apb_mem_arbiter

Overview:
- Shares one APB memory port between two APB requesters: requester 0 is the instruction fetch path and requester 1 is the load/store path.
- Sits between the fetch/LSU APB controllers and a unified memory.
- Arbitrates round-robin, runs a full APB setup/access sequence on the memory side, and forwards the completion to the winning requester.
- A watchdog terminates hung memory transfers with an error.

Parameters:
- ADDR_W, 32, address width of all APB ports.
- TIMEOUT_CYC, 64, number of access-phase cycles before a forced error completion; 0 disables the watchdog.
- FIRST_GRANT, 0, requester that wins the first contested arbitration after reset.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- r0_psel, r0_penable, r0_pwrite  in  1 each  requester 0 APB control
- r0_paddr  in  ADDR_W  requester 0 address
- r0_pwdata  in  32  requester 0 write data
- r0_pstrb  in  4  requester 0 byte strobes
- r0_prdata  out  32  requester 0 read data
- r0_pready, r0_pslverr  out  1 each  requester 0 completion and error
- r1_*  same set as r0_*  requester 1 (load/store)
- m_psel, m_penable, m_pwrite  out  1 each  memory-side APB control
- m_paddr  out  ADDR_W  memory-side address
- m_pwdata  out  32  memory-side write data
- m_pstrb  out  4  memory-side byte strobes
- m_prdata  in  32  memory read data
- m_pready, m_pslverr  in  1 each  memory completion and error
- busy_o  out  1  a transfer is in progress on the memory side

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, owner=none, last_grant=!FIRST_GRANT, watchdog counter=0.
  - All outputs 0: m_psel, m_penable, r*_pready, r*_pslverr, r*_prdata, busy_o.
  - Reset asserted mid-transfer abandons the transfer. No completion is ever issued for it.
- Request: a requester is pending when rX_psel=1. Requesters obey APB and hold psel/paddr/pwrite/pwdata/pstrb stable until they see rX_pready=1.
- FSM state IDLE:
  - One pending requester: it wins.
  - Both pending: the requester other than last_grant wins.
  - On a win: register owner and last_grant, go to SETUP.
- FSM state SETUP: m_psel=1, m_penable=0. Go to ACCESS unconditionally.
- FSM state ACCESS: m_psel=1, m_penable=1.
  - On m_pready=1, completion is forwarded combinationally in the same cycle: owner pready=1, pslverr=m_pslverr, prdata=m_prdata.
  - After completion, go to IDLE.
- Back-to-back: no direct ACCESS->SETUP transition. There is always one IDLE cycle, so m_psel is low for at least one cycle between transfers.
- Memory-side fields: m_paddr, m_pwrite, m_pwdata and m_pstrb are combinational muxes of the registered owner's inputs. They are 0 in IDLE.
- Non-owner requester: sees pready=0, pslverr=0, prdata=0 at all times.
- Latency with a zero-wait memory:
  - Requester setup in cycle 0, memory SETUP in cycle 1, memory ACCESS and requester completion in cycle 2.
  - Each memory wait state adds one cycle.
- Watchdog:
  - Counts ACCESS cycles with m_pready=0.
  - When the count equals TIMEOUT_CYC-1 and m_pready=0 in that cycle: owner gets pready=1, pslverr=1, prdata=0. Go to IDLE; m_psel drops next cycle.
  - m_pready=1 in the same cycle as the timeout: the normal completion wins.
- Simultaneous events: a new request arriving in the owner's completion cycle is only sampled in the next IDLE cycle.
- Owner dropping psel before completion is a protocol violation. The bench asserts on it; RTL behaviour is unspecified.
- busy_o = (state != IDLE).

Decomposition:
- typedefs package gets:
  - arb_state_e: IDLE, SETUP, ACCESS.
  - arb_owner_e: OWN_FETCH=0, OWN_LSU=1.
  - APB strobe width constant (4).
- Sub-module rr_arbiter_2:
  - Inputs: two request bits and last_grant.
  - Output: a one-hot grant.
  - Purely combinational; last_grant stays in the parent.
- Watchdog counter stays inline, width $clog2(TIMEOUT_CYC+1).

Test Plan:
- Single fetch read:
  - Stimulus: r0 read of 0x100, memory zero-wait, m_prdata=0xDEADBEEF.
  - Required: m_psel high in cycles 1-2, m_penable high in cycle 2, r0_pready=1 with r0_prdata=0xDEADBEEF in cycle 2.
- Contention:
  - Stimulus: r0 read of 0x200 and r1 write of 0x300 (pwdata=0x12345678, pstrb=0xF) in the same cycle, FIRST_GRANT=0.
  - Required: r0 served first, one IDLE cycle, then r1 write visible on the m_* pins; r1 never sees pready while r0 owns the port.
- Round-robin fairness:
  - Stimulus: both requesters continuously pending for 8 transfers.
  - Required: grants alternate 0,1,0,1,...; r1 waits no more than one r0 transfer.
- Wait states and error:
  - Stimulus: memory inserts 3 wait cycles then m_pslverr=1.
  - Required: owner gets pready and pslverr in cycle 5, with no earlier pready.
- Watchdog:
  - Stimulus: TIMEOUT_CYC=4, memory never asserts m_pready.
  - Required: owner gets pready=1, pslverr=1, prdata=0 on the 4th ACCESS cycle; m_psel=0 the next cycle; a pending r1 is granted afterwards.
- Reset mid-transfer:
  - Stimulus: assert rst during ACCESS.
  - Required: m_psel, m_penable, r*_pready and busy_o go to 0 asynchronously; after release the first contested grant goes to FIRST_GRANT.

Source files
------------

// File: rtl/apb_mem_arbiter_pkg.sv
// Shared types for the two-requester APB memory arbiter.
package apb_mem_arbiter_pkg;

    localparam int unsigned APB_DATA_W = 32;
    localparam int unsigned APB_STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_LSU   = 1'b1
    } arb_owner_e;

    // Write-side payload forwarded from the owning requester to memory.
    typedef struct packed {
        logic                  pwrite;
        logic [APB_DATA_W-1:0] pwdata;
        logic [APB_STRB_W-1:0] pstrb;
    } apb_wr_t;

endpackage

// File: rtl/apb_mem_arbiter_rr_arbiter_2.sv
// Two-way round-robin grant: on contention the requester that did not win last time wins.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt_c
);

    always_comb begin
        gnt_c = 2'b00;
        if (req == 2'b11) begin
            gnt_c = last_grant ? 2'b01 : 2'b10;
        end else begin
            gnt_c = req;
        end
    end

endmodule

// File: rtl/apb_mem_arbiter.sv
// Shares one APB memory port between the fetch (r0) and load/store (r1) requesters,
// with round-robin arbitration and a watchdog that error-terminates hung accesses.
module apb_mem_arbiter
    import apb_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned FIRST_GRANT = 0
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  r0_psel,
    input  logic                  r0_penable,
    input  logic                  r0_pwrite,
    input  logic [ADDR_W-1:0]     r0_paddr,
    input  logic [APB_DATA_W-1:0] r0_pwdata,
    input  logic [APB_STRB_W-1:0] r0_pstrb,
    output logic [APB_DATA_W-1:0] r0_prdata,
    output logic                  r0_pready,
    output logic                  r0_pslverr,

    input  logic                  r1_psel,
    input  logic                  r1_penable,
    input  logic                  r1_pwrite,
    input  logic [ADDR_W-1:0]     r1_paddr,
    input  logic [APB_DATA_W-1:0] r1_pwdata,
    input  logic [APB_STRB_W-1:0] r1_pstrb,
    output logic [APB_DATA_W-1:0] r1_prdata,
    output logic                  r1_pready,
    output logic                  r1_pslverr,

    output logic                  m_psel,
    output logic                  m_penable,
    output logic                  m_pwrite,
    output logic [ADDR_W-1:0]     m_paddr,
    output logic [APB_DATA_W-1:0] m_pwdata,
    output logic [APB_STRB_W-1:0] m_pstrb,
    input  logic [APB_DATA_W-1:0] m_prdata,
    input  logic                  m_pready,
    input  logic                  m_pslverr,

    output logic                  busy_o
);

    localparam int unsigned WD_W    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int unsigned WD_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam logic        WD_EN   = (TIMEOUT_CYC > 0);
    localparam logic        LAST_GRANT_RST = (FIRST_GRANT == 0) ? 1'b1 : 1'b0;

    arb_state_e      state_q, state_d;
    arb_owner_e      owner_q, owner_d;
    logic            last_grant_q, last_grant_d;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

    logic [1:0] gnt_c;
    logic       done_c;
    logic       timeout_c;
    logic       cpl_err_c;
    logic [APB_DATA_W-1:0] cpl_rdata_c;

    apb_wr_t r0_wr, r1_wr, own_wr;

    // The requesters' own access-phase strobe carries no information here; psel alone marks a request.
    logic unused_penable;
    assign unused_penable = r0_penable ^ r1_penable;

    rr_arbiter_2 u_rr (
        .req        ({r1_psel, r0_psel}),
        .last_grant (last_grant_q),
        .gnt_c      (gnt_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_FETCH;
            last_grant_q <= LAST_GRANT_RST;
            wd_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            wd_cnt_q     <= wd_cnt_d;
        end
    end

    // Next state; the watchdog only runs while stalled in ACCESS and clears everywhere else.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        wd_cnt_d     = '0;
        timeout_c    = 1'b0;
        done_c       = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_c != 2'b00) begin
                    owner_d      = gnt_c[1] ? OWN_LSU : OWN_FETCH;
                    last_grant_d = gnt_c[1];
                    state_d      = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                timeout_c = WD_EN && !m_pready && (wd_cnt_q == WD_W'(WD_LAST));
                done_c    = m_pready || timeout_c;
                if (done_c) begin
                    state_d = IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign r0_wr = '{pwrite: r0_pwrite, pwdata: r0_pwdata, pstrb: r0_pstrb};
    assign r1_wr = '{pwrite: r1_pwrite, pwdata: r1_pwdata, pstrb: r1_pstrb};

    // Memory-side request mirrors the registered owner and is quiet while idle.
    always_comb begin
        busy_o    = (state_q != IDLE);
        m_psel    = (state_q != IDLE);
        m_penable = (state_q == ACCESS);
        m_paddr   = '0;
        own_wr    = '0;
        if (state_q != IDLE) begin
            m_paddr = (owner_q == OWN_LSU) ? r1_paddr : r0_paddr;
            own_wr  = (owner_q == OWN_LSU) ? r1_wr : r0_wr;
        end
        m_pwrite = own_wr.pwrite;
        m_pwdata = own_wr.pwdata;
        m_pstrb  = own_wr.pstrb;
    end

    // Completion goes only to the owner; a watchdog completion carries an error and no data.
    always_comb begin
        cpl_err_c   = m_pready ? m_pslverr : 1'b1;
        cpl_rdata_c = m_pready ? m_prdata : '0;
        r0_pready   = 1'b0;
        r0_pslverr  = 1'b0;
        r0_prdata   = '0;
        r1_pready   = 1'b0;
        r1_pslverr  = 1'b0;
        r1_prdata   = '0;
        if (done_c) begin
            if (owner_q == OWN_LSU) begin
                r1_pready  = 1'b1;
                r1_pslverr = cpl_err_c;
                r1_prdata  = cpl_rdata_c;
            end else begin
                r0_pready  = 1'b1;
                r0_pslverr = cpl_err_c;
                r0_prdata  = cpl_rdata_c;
            end
        end
    end

endmodule

// File: tb/tb_apb_mem_arbiter.sv
// Directed bench for apb_mem_arbiter: vector table plus hand-written fairness and reset sequences.
module tb_apb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        r0_psel = 1'b0, r0_penable = 1'b0, r0_pwrite = 1'b0;
    logic [31:0] r0_paddr = '0, r0_pwdata = '0;
    logic [3:0]  r0_pstrb = '0;
    logic [31:0] r0_prdata;
    logic        r0_pready, r0_pslverr;

    logic        r1_psel = 1'b0, r1_penable = 1'b0, r1_pwrite = 1'b0;
    logic [31:0] r1_paddr = '0, r1_pwdata = '0;
    logic [3:0]  r1_pstrb = '0;
    logic [31:0] r1_prdata;
    logic        r1_pready, r1_pslverr;

    logic        m_psel, m_penable, m_pwrite;
    logic [31:0] m_paddr, m_pwdata, m_prdata;
    logic [3:0]  m_pstrb;
    logic        m_pready, m_pslverr;
    logic        busy_o;

    // Memory model knobs
    int          mem_wait  = 0;
    logic        mem_err   = 1'b0;
    logic        mem_hang  = 1'b0;
    logic [31:0] mem_rdata = '0;
    int          wcnt      = 0;

    int n_checks = 0;
    int n_fail   = 0;

    apb_mem_arbiter #(
        .ADDR_W      (32),
        .TIMEOUT_CYC (4),
        .FIRST_GRANT (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .r0_psel    (r0_psel),
        .r0_penable (r0_penable),
        .r0_pwrite  (r0_pwrite),
        .r0_paddr   (r0_paddr),
        .r0_pwdata  (r0_pwdata),
        .r0_pstrb   (r0_pstrb),
        .r0_prdata  (r0_prdata),
        .r0_pready  (r0_pready),
        .r0_pslverr (r0_pslverr),
        .r1_psel    (r1_psel),
        .r1_penable (r1_penable),
        .r1_pwrite  (r1_pwrite),
        .r1_paddr   (r1_paddr),
        .r1_pwdata  (r1_pwdata),
        .r1_pstrb   (r1_pstrb),
        .r1_prdata  (r1_prdata),
        .r1_pready  (r1_pready),
        .r1_pslverr (r1_pslverr),
        .m_psel     (m_psel),
        .m_penable  (m_penable),
        .m_pwrite   (m_pwrite),
        .m_paddr    (m_paddr),
        .m_pwdata   (m_pwdata),
        .m_pstrb    (m_pstrb),
        .m_prdata   (m_prdata),
        .m_pready   (m_pready),
        .m_pslverr  (m_pslverr),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    assign m_pready  = m_psel & m_penable & ~mem_hang & (wcnt >= mem_wait);
    assign m_prdata  = mem_rdata;
    assign m_pslverr = mem_err;

    always @(posedge clk) begin
        if (m_psel && m_penable && !m_pready) wcnt <= wcnt + 1;
        else                                  wcnt <= 0;
    end

    always @(negedge clk) begin
        if (!rst && m_penable)
            assert (r0_psel || r1_psel) else $error("requester dropped psel during access");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Follows one transfer from its IDLE cycle (cycle 0) to the owner's completion.
    task automatic run_xfer(input string nm, input int owner, input int exp_lat,
                            input logic [31:0] exp_rdata, input logic exp_err);
        bit          done = 1'b0;
        logic [31:0] e_addr, e_wdata;
        logic        e_write;
        logic [3:0]  e_strb;
        logic        own_rdy, oth_rdy;
        e_addr  = (owner == 1) ? r1_paddr  : r0_paddr;
        e_wdata = (owner == 1) ? r1_pwdata : r0_pwdata;
        e_write = (owner == 1) ? r1_pwrite : r0_pwrite;
        e_strb  = (owner == 1) ? r1_pstrb  : r0_pstrb;
        for (int c = 0; c < exp_lat + 4 && !done; c++) begin
            @(negedge clk);
            own_rdy = (owner == 1) ? r1_pready : r0_pready;
            oth_rdy = (owner == 1) ? r0_pready : r1_pready;
            if (c == 0) begin
                chk({nm, "_idle_psel"}, 32'(m_psel), 32'd0);
                chk({nm, "_idle_paddr"}, m_paddr, 32'd0);
            end
            if (c == 1) begin
                chk({nm, "_setup_psel"}, 32'(m_psel), 32'd1);
                chk({nm, "_setup_penable"}, 32'(m_penable), 32'd0);
                chk({nm, "_paddr"}, m_paddr, e_addr);
                chk({nm, "_pwrite"}, 32'(m_pwrite), 32'(e_write));
                chk({nm, "_pwdata"}, m_pwdata, e_wdata);
                chk({nm, "_pstrb"}, 32'(m_pstrb), 32'(e_strb));
                chk({nm, "_busy"}, 32'(busy_o), 32'd1);
            end
            if (c == 2) chk({nm, "_access_penable"}, 32'(m_penable), 32'd1);
            chk({nm, "_other_pready"}, 32'(oth_rdy), 32'd0);
            if (own_rdy) begin
                done = 1'b1;
                chk({nm, "_latency"}, 32'(c), 32'(exp_lat));
                chk({nm, "_prdata"}, (owner == 1) ? r1_prdata : r0_prdata, exp_rdata);
                chk({nm, "_pslverr"}, 32'((owner == 1) ? r1_pslverr : r0_pslverr), 32'(exp_err));
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: no pready seen, required within %0d cycles", nm, exp_lat);
        end
    endtask

    typedef struct {
        logic [1:0]  new_req;
        logic [31:0] a0; logic w0; logic [31:0] wd0; logic [3:0] s0;
        logic [31:0] a1; logic w1; logic [31:0] wd1; logic [3:0] s1;
        int          wait_n;
        logic        err;
        logic        hang;
        logic [31:0] rdata;
        int          exp_owner;
        int          exp_lat;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        // contention after reset: r0 first, then r1's write
        vecs[0] = '{2'b11, 32'h200, 1'b0, 32'h0, 4'h0, 32'h300, 1'b1, 32'h12345678, 4'hF,
                    0, 1'b0, 1'b0, 32'h11111111, 0, 2, 32'h11111111, 1'b0};
        vecs[1] = '{2'b00, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0,
                    0, 1'b0, 1'b0, 32'h22222222, 1, 2, 32'h22222222, 1'b0};
        // single fetch read
        vecs[2] = '{2'b01, 32'h100, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0,
                    0, 1'b0, 1'b0, 32'hDEADBEEF, 0, 2, 32'hDEADBEEF, 1'b0};
        // 3 wait states + slave error; ready coincides with the watchdog limit
        vecs[3] = '{2'b10, 32'h0, 1'b0, 32'h0, 4'h0, 32'h400, 1'b0, 32'h0, 4'h0,
                    3, 1'b1, 1'b0, 32'hCAFE0001, 1, 5, 32'hCAFE0001, 1'b1};
        vecs[4] = '{2'b01, 32'h104, 1'b1, 32'hA5A5A5A5, 4'h3, 32'h0, 1'b0, 32'h0, 4'h0,
                    1, 1'b0, 1'b0, 32'h0F0F0F0F, 0, 3, 32'h0F0F0F0F, 1'b0};
        // contention with last grant = r0, so r1 wins
        vecs[5] = '{2'b11, 32'h108, 1'b0, 32'h0, 4'h0, 32'h500, 1'b0, 32'h0, 4'h0,
                    0, 1'b0, 1'b0, 32'h33333333, 1, 2, 32'h33333333, 1'b0};
        // watchdog: hung memory, r1 waits behind it
        vecs[6] = '{2'b10, 32'h0, 1'b0, 32'h0, 4'h0, 32'h600, 1'b0, 32'h0, 4'h0,
                    0, 1'b0, 1'b1, 32'h44444444, 0, 5, 32'h0, 1'b1};
        vecs[7] = '{2'b00, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0,
                    0, 1'b0, 1'b0, 32'h55555555, 1, 2, 32'h55555555, 1'b0};

        #12;
        chk("rst_m_psel", 32'(m_psel), 32'd0);
        chk("rst_m_penable", 32'(m_penable), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_r0_pready", 32'(r0_pready), 32'd0);
        chk("rst_r1_pready", 32'(r1_pready), 32'd0);
        chk("rst_r0_prdata", r0_prdata, 32'd0);
        chk("rst_r1_pslverr", 32'(r1_pslverr), 32'd0);

        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].new_req[0]) begin
                r0_psel = 1'b1; r0_paddr = vecs[i].a0; r0_pwrite = vecs[i].w0;
                r0_pwdata = vecs[i].wd0; r0_pstrb = vecs[i].s0;
            end
            if (vecs[i].new_req[1]) begin
                r1_psel = 1'b1; r1_paddr = vecs[i].a1; r1_pwrite = vecs[i].w1;
                r1_pwdata = vecs[i].wd1; r1_pstrb = vecs[i].s1;
            end
            mem_wait  = vecs[i].wait_n;
            mem_err   = vecs[i].err;
            mem_hang  = vecs[i].hang;
            mem_rdata = vecs[i].rdata;
            run_xfer($sformatf("vec%0d", i), vecs[i].exp_owner, vecs[i].exp_lat,
                     vecs[i].exp_rdata, vecs[i].exp_err);
            @(posedge clk); #1;
            if (vecs[i].exp_owner == 1) r1_psel = 1'b0;
            else                        r0_psel = 1'b0;
        end

        // Fairness: both held pending; last grant was r1, so r0 leads and they alternate.
        r0_psel = 1'b1; r0_paddr = 32'h800; r0_pwrite = 1'b0; r0_pwdata = 32'h0;       r0_pstrb = 4'h0;
        r1_psel = 1'b1; r1_paddr = 32'h900; r1_pwrite = 1'b1; r1_pwdata = 32'hBEEF0000; r1_pstrb = 4'hC;
        mem_wait = 0; mem_err = 1'b0; mem_hang = 1'b0;
        for (int k = 0; k < 8; k++) begin
            mem_rdata = 32'h70000000 + 32'(k);
            run_xfer($sformatf("rr%0d", k), k % 2, 2, 32'h70000000 + 32'(k), 1'b0);
            @(posedge clk); #1;
        end
        r0_psel = 1'b0; r1_psel = 1'b0;

        // Reset during ACCESS: everything drops at once, and the first contest goes to r0 again.
        r0_psel = 1'b1; r0_paddr = 32'h700; r0_pwrite = 1'b0;
        mem_rdata = 32'h00000099;
        @(posedge clk); #1;
        r1_psel = 1'b1; r1_paddr = 32'h704; r1_pwrite = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_r0_pready", 32'(r0_pready), 32'd1);
        chk("pre_rst_r0_prdata", r0_prdata, 32'h00000099);
        #2 rst = 1'b1;
        #1;
        chk("arst_m_psel", 32'(m_psel), 32'd0);
        chk("arst_m_penable", 32'(m_penable), 32'd0);
        chk("arst_r0_pready", 32'(r0_pready), 32'd0);
        chk("arst_r1_pready", 32'(r1_pready), 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_r0_prdata", r0_prdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_rdata = 32'h000000AA;
        run_xfer("post_rst", 0, 2, 32'h000000AA, 1'b0);
        @(posedge clk); #1;
        r0_psel = 1'b0;
        mem_rdata = 32'h000000BB;
        run_xfer("post_rst_r1", 1, 2, 32'h000000BB, 1'b0);
        @(posedge clk); #1;
        r1_psel = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
